// File: rtl/risac_bus_arbiter.sv
// risac_bus_arbiter
//   Two-requester arbiter that places an instruction bus (avIB, read-only)
//   and a data bus (avDB, read/write) onto one shared memory master port
//   (avM). Only one owner holds the port at a time. A grant ends when the
//   owner's transfer completes or when the owner drops its request, and
//   one idle bubble cycle always separates two grants.
//
//   Build option: macro ARB_ROUND_ROBIN_EN
//     defined   - contention goes to the requester not served last
//     undefined - fixed priority, the data bus always wins contention
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   avIB_address/read          instruction request
//   avIB_readdata/waitrequest  instruction response and stall
//   avDB_address/read/write    data request
//   avDB_writedata/byteenable  data write payload and byte lanes
//   avDB_readdata/waitrequest  data response and stall
//   avM_*                      shared memory master command and response
module risac_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [ADDR_W-1:0]   avIB_address,
    input  logic                avIB_read,
    output logic [DATA_W-1:0]   avIB_readdata,
    output logic                avIB_waitrequest,

    input  logic [ADDR_W-1:0]   avDB_address,
    input  logic                avDB_read,
    input  logic                avDB_write,
    input  logic [DATA_W-1:0]   avDB_writedata,
    input  logic [DATA_W/8-1:0] avDB_byteenable,
    output logic [DATA_W-1:0]   avDB_readdata,
    output logic                avDB_waitrequest,

    output logic [ADDR_W-1:0]   avM_address,
    output logic                avM_read,
    output logic                avM_write,
    output logic [DATA_W-1:0]   avM_writedata,
    output logic [DATA_W/8-1:0] avM_byteenable,
    input  logic [DATA_W-1:0]   avM_readdata,
    input  logic                avM_waitrequest
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic req_i, req_d;
    logic done_i, done_d;
    logic d_wins;

    assign req_i  = avIB_read;
    assign req_d  = avDB_read | avDB_write;
    assign done_i = (state == GNT_I) & req_i & ~avM_waitrequest;
    assign done_d = (state == GNT_D) & req_d & ~avM_waitrequest;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the data bus completed the most recent transfer; reset value
    // of 0 (instruction last) hands the first contention to the data bus.
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (done_i) begin
            last_d <= 1'b0;
        end else if (done_d) begin
            last_d <= 1'b1;
        end
    end

    assign d_wins = ~last_d;
`else
    assign d_wins = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A grant is released either on completion or when the owner abandons
    // its request; both paths return to IDLE, giving the bubble cycle.
    always_comb begin
        state_nxt        = state;
        avM_address      = '0;
        avM_read         = 1'b0;
        avM_write        = 1'b0;
        avM_writedata    = '0;
        avM_byteenable   = '0;
        avIB_waitrequest = req_i;
        avDB_waitrequest = req_d;

        unique case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    state_nxt = d_wins ? GNT_D : GNT_I;
                end else if (req_d) begin
                    state_nxt = GNT_D;
                end else if (req_i) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I: begin
                avM_address      = avIB_address;
                avM_read         = avIB_read;
                avM_byteenable   = '1;
                avIB_waitrequest = ~done_i;
                if (!req_i || done_i) begin
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                avM_address      = avDB_address;
                avM_write        = avDB_write;
                // A simultaneous read+write is carried out as a write.
                avM_read         = avDB_read & ~avDB_write;
                avM_writedata    = avDB_writedata;
                avM_byteenable   = avDB_byteenable;
                avDB_waitrequest = ~done_d;
                if (!req_d || done_d) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign avIB_readdata = avM_readdata;
    assign avDB_readdata = avM_readdata;

endmodule

// File: tb/tb_risac_bus_arbiter.sv
module tb_risac_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ib_addr, db_addr, db_wdata, m_rdata;
    logic        ib_rd, db_rd, db_wr, m_wait;
    logic [3:0]  db_be;
    logic [31:0] ib_rdata, db_rdata, m_addr, m_wdata;
    logic        ib_wait, db_wait, m_rd, m_wr;
    logic [3:0]  m_be;

    int total = 0;
    int bad   = 0;

    risac_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .avIB_address     (ib_addr),
        .avIB_read        (ib_rd),
        .avIB_readdata    (ib_rdata),
        .avIB_waitrequest (ib_wait),
        .avDB_address     (db_addr),
        .avDB_read        (db_rd),
        .avDB_write       (db_wr),
        .avDB_writedata   (db_wdata),
        .avDB_byteenable  (db_be),
        .avDB_readdata    (db_rdata),
        .avDB_waitrequest (db_wait),
        .avM_address      (m_addr),
        .avM_read         (m_rd),
        .avM_write        (m_wr),
        .avM_writedata    (m_wdata),
        .avM_byteenable   (m_be),
        .avM_readdata     (m_rdata),
        .avM_waitrequest  (m_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ib_addr = '0; ib_rd = 1'b0;
        db_addr = '0; db_rd = 1'b0; db_wr = 1'b0; db_wdata = '0; db_be = '0;
        m_rdata = '0; m_wait = 1'b0;

        // reset values
        #2;
        chk("rst_m_rd", m_rd, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_m_be", m_be, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_ib_wait_noreq", ib_wait, 0);
        chk("rst_db_wait_noreq", db_wait, 0);
        ib_rd = 1'b1;
        #1;
        chk("rst_ib_wait_req", ib_wait, 1);
        chk("rst_m_rd_req", m_rd, 0);
        ib_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // instruction read, zero wait
        ib_addr = 32'h100; ib_rd = 1'b1; m_wait = 1'b0; m_rdata = 32'hDEADBEEF;
        #1;
        chk("i_idle_m_rd", m_rd, 0);
        chk("i_idle_wait", ib_wait, 1);
        tick();
        chk("i_m_rd", m_rd, 1);
        chk("i_m_addr", m_addr, 32'h100);
        chk("i_m_be", m_be, 4'hF);
        chk("i_m_wr", m_wr, 0);
        chk("i_wait", ib_wait, 0);
        chk("i_rdata", ib_rdata, 32'hDEADBEEF);
        tick();
        ib_rd = 1'b0;
        #1;
        chk("i_after_m_rd", m_rd, 0);

        // data write, two memory wait cycles
        db_addr = 32'h2004; db_wdata = 32'h12345678; db_be = 4'h3; db_wr = 1'b1;
        m_wait = 1'b1;
        tick();
        chk("d_c1_m_wr", m_wr, 1);
        chk("d_c1_addr", m_addr, 32'h2004);
        chk("d_c1_wdata", m_wdata, 32'h12345678);
        chk("d_c1_be", m_be, 4'h3);
        chk("d_c1_wait", db_wait, 1);
        tick();
        chk("d_c2_m_wr", m_wr, 1);
        chk("d_c2_wait", db_wait, 1);
        tick();
        m_wait = 1'b0;
        #1;
        chk("d_c3_m_wr", m_wr, 1);
        chk("d_c3_wait", db_wait, 0);
        tick();
        db_wr = 1'b0;
        #1;
        chk("d_after_m_wr", m_wr, 0);

        // continuous contention, zero-wait memory
        do_reset();
        ib_addr = 32'h300; db_addr = 32'h400; db_rd = 1'b1; ib_rd = 1'b1;
        for (int g = 0; g < 4; g++) begin
            logic exp_d;
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (g % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            tick();
            chk("arb_addr", m_addr, exp_d ? 32'h400 : 32'h300);
            chk("arb_m_rd", m_rd, 1);
            chk("arb_db_wait", db_wait, exp_d ? 0 : 1);
            chk("arb_ib_wait", ib_wait, exp_d ? 1 : 0);
            tick();
            chk("arb_bubble_rd", m_rd, 0);
            chk("arb_bubble_ibw", ib_wait, 1);
        end
        ib_rd = 1'b0; db_rd = 1'b0;
        tick();

        // reset mid-transfer
        db_addr = 32'h500; db_wr = 1'b1; m_wait = 1'b1;
        tick();
        chk("rm_m_wr_before", m_wr, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_m_wr_async", m_wr, 0);
        chk("rm_db_wait", db_wait, 1);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rm_idle_m_wr", m_wr, 0);
        tick();
        chk("rm_regrant_m_wr", m_wr, 1);
        m_wait = 1'b0;
        #1;
        chk("rm_regrant_wait", db_wait, 0);
        tick();
        db_wr = 1'b0;

        // read+write together is a write
        db_rd = 1'b1; db_wr = 1'b1; db_addr = 32'h600;
        tick();
        chk("rw_m_wr", m_wr, 1);
        chk("rw_m_rd", m_rd, 0);
        tick();
        db_rd = 1'b0; db_wr = 1'b0;
        tick();

        // instruction owner abandons its request while stalled
        ib_addr = 32'h700; ib_rd = 1'b1; m_wait = 1'b1;
        tick();
        chk("drop_m_rd", m_rd, 1);
        db_addr = 32'h800; db_wr = 1'b1;
        #1;
        chk("drop_db_wait_nonowner", db_wait, 1);
        chk("drop_ib_wait", ib_wait, 1);
        tick();
        ib_rd = 1'b0;
        tick();
        chk("drop_idle_m_rd", m_rd, 0);
        chk("drop_idle_m_wr", m_wr, 0);
        chk("drop_idle_db_wait", db_wait, 1);
        tick();
        chk("drop_d_m_wr", m_wr, 1);
        chk("drop_d_addr", m_addr, 32'h800);
        m_wait = 1'b0;
        tick();
        db_wr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
